simon_game_core: RTL and testbench

SIMON_GAME_CORE -- requirements
Module: simon_game_core

---
 rtl/simon_game_core.sv | 180 ++++++++++++++++++
 tb/tb_simon_game_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_game_core.sv
// Simon memory game: LFSR-generated sequence, timed LED playback, player echo with timeout.
// IDLE=0 wait | EXTEND=1 append symbol | SHOW_ON=2/SHOW_OFF=3 playback | WAIT_IN=4 echo | LOSE=5 | WIN=6
module simon_game_core #(
   parameter int          N_BTN         = 4,
   parameter int          MAX_LEN       = 16,
   parameter int          ON_TICKS      = 50,
   parameter int          OFF_TICKS     = 25,
   parameter int          TIMEOUT_TICKS = 500,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic                             btn_clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [N_BTN-1:0]                 btn_rise,
   output logic [N_BTN-1:0]                 led,
   output logic                             error_led,
   output logic                             win_led,
   output logic [$clog2(MAX_LEN+1)-1:0]     level,
   output logic [2:0]                       state
);

   localparam int SYM_W    = $clog2(N_BTN);
   localparam int IDX_W    = $clog2(MAX_LEN);
   localparam int LVL_W    = $clog2(MAX_LEN + 1);
   localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TICK_W   = $clog2(TICK_MAX + 1);
   localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXTEND   = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_OFF = 3'd3,
      S_WAIT_IN  = 3'd4,
      S_LOSE     = 3'd5,
      S_WIN      = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [N_BTN-1:0]   flash_q, flash_d;
   logic [SYM_W-1:0]   seq_q [MAX_LEN];

   logic               seq_we;
   logic [SYM_W-1:0]   new_sym;
   logic [SYM_W-1:0]   cur_sym;
   logic [SYM_W-1:0]   pressed;
   logic               press_valid;
   logic               last_idx;

   always_ff @(posedge btn_clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
         to_q    <= '0;
         lfsr_q  <= SEED_EFF;
         flash_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         to_q    <= to_d;
         lfsr_q  <= lfsr_d;
         flash_q <= flash_d;
      end
   end

   // Storage is never read before its EXTEND write, so it carries no reset.
   always_ff @(posedge btn_clk) begin
      if (seq_we) begin
         seq_q[level_q[IDX_W-1:0]] <= new_sym;
      end
   end

   assign lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
   assign new_sym     = lfsr_q[SYM_W-1:0];
   assign cur_sym     = seq_q[idx_q];
   assign press_valid = |btn_rise;
   assign last_idx    = (LVL_W'(idx_q) == (level_q - LVL_W'(1)));

   always_comb begin
      pressed = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_rise[i]) pressed = SYM_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      idx_d   = idx_q;
      tick_d  = tick_q;
      to_d    = to_q;
      flash_d = '0;
      seq_we  = 1'b0;
      case (state_q)
         S_IDLE, S_LOSE, S_WIN: begin
            if (start) begin
               level_d = '0;
               state_d = S_EXTEND;
            end
         end
         S_EXTEND: begin
            seq_we  = 1'b1;
            level_d = level_q + LVL_W'(1);
            idx_d   = '0;
            tick_d  = '0;
            to_d    = '0;
            state_d = S_SHOW_ON;
         end
         S_SHOW_ON: begin
            if (tick_q == TICK_W'(ON_TICKS - 1)) begin
               tick_d  = '0;
               state_d = S_SHOW_OFF;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         S_SHOW_OFF: begin
            if (tick_q == TICK_W'(OFF_TICKS - 1)) begin
               tick_d = '0;
               if (last_idx) begin
                  idx_d   = '0;
                  to_d    = '0;
                  state_d = S_WAIT_IN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_SHOW_ON;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         S_WAIT_IN: begin
            if (press_valid) begin
               if (pressed == cur_sym) begin
                  flash_d = N_BTN'(1) << pressed;
                  to_d    = '0;
                  if (last_idx) begin
                     state_d = (level_q == LVL_W'(MAX_LEN)) ? S_WIN : S_EXTEND;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  state_d = S_LOSE;
               end
            end else if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
               state_d = S_LOSE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      led = '0;
      case (state_q)
         S_SHOW_ON:     led = N_BTN'(1) << cur_sym;
         S_WAIT_IN:     led = flash_q;
         S_LOSE, S_WIN: led = '1;
         default:       led = '0;
      endcase
   end

   assign error_led = (state_q == S_LOSE);
   assign win_led   = (state_q == S_WIN);
   assign level     = level_q;
   assign state     = state_q;

endmodule

// File: tb/tb_simon_game_core.sv
// Directed game scenarios with random button noise, checked against a sequence/LFSR reference model.
module tb_simon_game_core;
   localparam int          N_BTN   = 4;
   localparam int          MAX_LEN = 2;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic       btn_clk = 1'b0;
   logic       reset   = 1'b1;
   logic       start   = 1'b0;
   logic [3:0] btn_rise = 4'b0000;
   logic [3:0] led;
   logic       error_led;
   logic       win_led;
   logic [1:0] level;
   logic [2:0] state;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   logic [1:0] seq_m [MAX_LEN];

   simon_game_core #(
      .N_BTN(N_BTN), .MAX_LEN(MAX_LEN), .ON_TICKS(2), .OFF_TICKS(1),
      .TIMEOUT_TICKS(10), .SEED(SEED)
   ) dut (
      .btn_clk(btn_clk), .reset(reset), .start(start), .btn_rise(btn_rise),
      .led(led), .error_led(error_led), .win_led(win_led),
      .level(level), .state(state)
   );

   always #5 btn_clk = ~btn_clk;

   // Clock edges since reset release; the LFSR has advanced exactly this many times.
   always @(posedge btn_clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [15:0] lfsr_at(int n);
      logic [15:0] v;
      v = SEED;
      for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   function automatic logic [3:0] onehot(logic [1:0] s);
      logic [3:0] r;
      r = 4'b0001 << s;
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge btn_clk);
   endtask

   task automatic press(logic [3:0] v);
      btn_rise = v;
      step();
      btn_rise = 4'b0000;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("extend_state", state, 1);
   endtask

   // Entered at the negedge where EXTEND is visible; leaves at the first WAIT_IN negedge.
   task automatic play_round(int l);
      logic [15:0] v;
      v = lfsr_at(cyc);
      seq_m[l-1] = v[1:0];
      chk("extend_level", level, l - 1);
      for (int i = 0; i < l; i++) begin
         step();
         chk("show_on1_state", state, 2);
         chk("show_on1_led", led, onehot(seq_m[i]));
         btn_rise = 4'($urandom_range(1, 15));
         step();
         btn_rise = 4'b0000;
         chk("show_on2_state", state, 2);
         chk("show_on2_led", led, onehot(seq_m[i]));
         start = 1'b1;
         step();
         start = 1'b0;
         chk("show_off_state", state, 3);
         chk("show_off_led", led, 0);
      end
      step();
      chk("wait_state", state, 4);
      chk("wait_level", level, l);
   endtask

   task automatic press_ok(int i);
      logic [3:0] up;
      logic [3:0] v;
      if (seq_m[i] == 2'd1) begin
         v = 4'b0110;
      end else begin
         up = 4'hF << (int'(seq_m[i]) + 1);
         v  = onehot(seq_m[i]) | (4'($urandom_range(0, 15)) & up);
      end
      press(v);
   endtask

   initial begin
      logic [1:0] w;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_level", level, 0);
      chk("rst_led", led, 0);
      chk("rst_err", error_led, 0);
      chk("rst_win", win_led, 0);

      press(4'($urandom_range(1, 15)));
      chk("idle_btn_state", state, 0);
      chk("idle_btn_led", led, 0);
      repeat ($urandom_range(0, 4)) step();

      // Full win through level 2.
      do_start();
      play_round(1);
      press_ok(0);
      chk("l1_done_state", state, 1);
      play_round(2);
      press_ok(0);
      chk("l2_mid_state", state, 4);
      chk("l2_flash_led", led, onehot(seq_m[0]));
      step();
      chk("l2_flash_off", led, 0);
      press_ok(1);
      chk("win_state", state, 6);
      chk("win_led", win_led, 1);
      chk("win_leds", led, 4'hF);
      chk("win_level", level, 2);
      chk("win_err", error_led, 0);
      press(4'($urandom_range(1, 15)));
      repeat (3) step();
      chk("win_hold_state", state, 6);
      chk("win_hold_level", level, 2);

      // Wrong press at idx 0.
      do_start();
      play_round(1);
      w = seq_m[0] + 2'($urandom_range(1, 3));
      press(onehot(w));
      chk("lose_state", state, 5);
      chk("lose_err", error_led, 1);
      chk("lose_leds", led, 4'hF);
      chk("lose_level", level, 1);
      chk("lose_win", win_led, 0);
      repeat (2) step();
      press(4'($urandom_range(1, 15)));
      chk("lose_hold_state", state, 5);
      chk("lose_hold_level", level, 1);

      // Plain timeout after a fresh start.
      do_start();
      play_round(1);
      repeat (9) step();
      chk("to_pre_state", state, 4);
      step();
      chk("to_state", state, 5);
      chk("to_err", error_led, 1);

      // Press on the 9th idle cycle restarts the timeout.
      do_start();
      play_round(1);
      press_ok(0);
      chk("to2_ext_state", state, 1);
      play_round(2);
      repeat (8) step();
      chk("to2_pre_state", state, 4);
      press_ok(0);
      chk("to2_press_state", state, 4);
      repeat (9) step();
      chk("to2_hold_state", state, 4);
      step();
      chk("to2_state", state, 5);

      // Asynchronous reset in the middle of playback.
      do_start();
      step();
      chk("mid_show_state", state, 2);
      #2 reset = 1'b1;
      #1;
      chk("arst_state", state, 0);
      chk("arst_led", led, 0);
      chk("arst_level", level, 0);
      chk("arst_err", error_led, 0);
      chk("arst_win", win_led, 0);
      repeat (2) step();
      reset = 1'b0;
      repeat ($urandom_range(0, 4)) step();
      do_start();
      play_round(1);
      press_ok(0);
      chk("post_rst_ext", state, 1);
      play_round(2);
      press_ok(0);
      press_ok(1);
      chk("post_rst_win", state, 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
